// File: rtl/muldiv_seq_if.sv
// Execute-stage handshake bundle for the iterative multiply/divide unit.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, srca, srcb, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, srca, srcb, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer (radix-2 shift-add / restoring divide).
// Optional MULDIV_EARLY_OUT_EN: trivial cases skip the iteration loop.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start
// PREP   | take magnitudes, record signs, detect divide corner cases
// MUL    | WIDTH shift-add iterations
// DIV    | WIDTH restoring-divide iterations
// FIXUP  | apply signs / corner-case overrides, register result
// DONE   | one-cycle done pulse, may accept the next start
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_MUL,
        S_DIV,
        S_FIXUP,
        S_DONE
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic                 dz_q, dz_d;
    logic                 ovf_q, ovf_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic                 signed_a, signed_b, neg_a, neg_b;
    logic                 div_zero, div_ovf;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH+1:0]     div_diff;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quot_s, rem_s;
    logic [WIDTH-1:0]     sel;
    logic                 early;

    // Operand signedness and divide corner cases, evaluated on captured operands
    always_comb begin
        signed_a = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
        signed_b = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
        neg_a    = signed_a & a_q[WIDTH-1];
        neg_b    = signed_b & b_q[WIDTH-1];
        a_mag    = neg_a ? -a_q : a_q;
        b_mag    = neg_b ? -b_q : b_q;
        div_zero = op_q[2] && (b_q == '0);
        div_ovf  = op_q[2] && !op_q[0] && (a_q == MIN_VAL) && (b_q == '1);
    end

    // One iteration of each datapath
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
        if (prod_q[0]) begin
            mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
        end
        mul_next = {mul_sum, prod_q[WIDTH-1:1]};

        // Partial remainder is always below the divisor, so the kept value fits WIDTH bits
        div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        div_rem   = div_diff[WIDTH+1] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        div_next  = {div_rem, prod_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
    end

    always_comb begin
        prod_s = neg_q ? -prod_q : prod_q;
        quot_s = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        rem_s  = neg_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
        sel    = '0;
        case (op_q)
            OP_MUL:                      sel = prod_s[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: sel = prod_s[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU: begin
                if (dz_q)       sel = '1;
                else if (ovf_q) sel = MIN_VAL;
                else            sel = quot_s;
            end
            default: begin
                if (dz_q)       sel = a_q;
                else if (ovf_q) sel = '0;
                else            sel = rem_s;
            end
        endcase
    end

    always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
        early = op_q[2] ? (div_zero || div_ovf) : ((a_q == '0) || (b_q == '0));
`else
        early = 1'b0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = bus.srca;
                    b_d     = bus.srcb;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                cnt_d = CNT_LAST;
                neg_d = (op_q[2] && op_q[1]) ? neg_a : (neg_a ^ neg_b);
                dz_d  = div_zero;
                ovf_d = div_ovf;
                if (!op_q[2]) begin
                    a_d     = a_mag;
                    prod_d  = {{WIDTH{1'b0}}, b_mag};
                    state_d = S_MUL;
                end else begin
                    // Dividend keeps its original value for the divide-by-zero remainder
                    b_d     = b_mag;
                    prod_d  = {{WIDTH{1'b0}}, a_mag};
                    state_d = S_DIV;
                end
                if (early) begin
                    if (!op_q[2]) prod_d = '0;
                    state_d = S_FIXUP;
                end
            end
            S_MUL: begin
                prod_d = mul_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = S_FIXUP;
                end
            end
            S_DIV: begin
                prod_d = div_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                result_d = sel;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q == S_PREP) || (state_q == S_MUL) ||
                        (state_q == S_DIV)  || (state_q == S_FIXUP);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq; expected latencies follow MULDIV_EARLY_OUT_EN.
module tb_muldiv_seq;
    logic clk;
    logic rst_n;
    int   total  = 0;
    int   passes = 0;
    int   fails  = 0;

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one op in the current cycle (cycle 0) and follows it to its done pulse
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input bit early);
        int lat;
        int done_at;
        bit busy_ok;
        lat = 35;
`ifdef MULDIV_EARLY_OUT_EN
        if (early) lat = 3;
`else
        if (early) lat = 35;
`endif
        bus.start = 1'b1;
        bus.op    = o;
        bus.srca  = a;
        bus.srcb  = b;
        done_at   = -1;
        busy_ok   = 1'b1;
        for (int n = 1; n <= 60 && done_at < 0; n++) begin
            step();
            bus.start = 1'b0;
            bus.op    = 3'($urandom);
            bus.srca  = $urandom;
            bus.srcb  = $urandom;
            if (bus.done) begin
                done_at = n;
                if (bus.busy) busy_ok = 1'b0;
            end else if (!bus.busy) begin
                busy_ok = 1'b0;
            end
        end
        chk({tag, " latency"}, 32'(done_at), 32'(lat));
        chk({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, " result"}, bus.result, exp_r);
    endtask

    initial begin
        int extra;
        int done_at;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.srca  = '0;
        bus.srcb  = '0;
        bus.flush = 1'b0;
        #23;
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset result", bus.result, 32'd0);
        rst_n = 1'b1;
        step();

        run_op("mul 7x-3",        3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("mulh min*min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        run_op("mulhu ff*ff",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("mulhsu ff*ff",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("div -7/2",        3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0);
        run_op("rem -7/2",        3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0);
        run_op("divu 100/7",      3'b101, 32'd100,      32'd7,        32'd14,        1'b0);
        run_op("remu 100/7",      3'b111, 32'd100,      32'd7,        32'd2,         1'b0);
        run_op("divu 5/0",        3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1'b1);
        run_op("remu 5/0",        3'b111, 32'd5,        32'd0,        32'd5,         1'b1);
        run_op("div ovf",         3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("rem ovf",         3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1);
        run_op("div -5/0",        3'b100, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFF, 1'b1);
        run_op("rem -5/0",        3'b110, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 1'b1);
        run_op("mul 0x5",         3'b000, 32'd0,        32'd5,        32'd0,         1'b1);
        run_op("divu 100/7 again",3'b101, 32'd100,      32'd7,        32'd14,        1'b0);

        // Flush a DIV during its cycle 10
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.srca  = 32'hFFFF_FFF9;
        bus.srcb  = 32'd2;
        for (int n = 1; n <= 10; n++) begin
            step();
            bus.start = 1'b0;
            if (n == 10) bus.flush = 1'b1;
        end
        step();
        bus.flush = 1'b0;
        chk("flush busy", {31'd0, bus.busy}, 32'd0);
        chk("flush done", {31'd0, bus.done}, 32'd0);
        chk("flush result", bus.result, 32'd14);
        extra = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (bus.done) extra++;
        end
        chk("flush no done", 32'(extra), 32'd0);
        run_op("mul 6x7", 3'b000, 32'd6, 32'd7, 32'd42, 1'b0);

        // start held across DONE: second op taken in the DONE cycle
        step();
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.srca  = 32'd3;
        bus.srcb  = 32'd5;
        done_at   = -1;
        for (int n = 1; n <= 60 && done_at < 0; n++) begin
            step();
            bus.op   = 3'b101;
            bus.srca = 32'd100;
            bus.srcb = 32'd7;
            if (bus.done) done_at = n;
        end
        chk("b2b first latency", 32'(done_at), 32'd35);
        chk("b2b first result", bus.result, 32'd15);
        done_at = -1;
        for (int m = 1; m <= 60 && done_at < 0; m++) begin
            step();
            bus.start = (m == 5);
            if (m == 5) begin
                bus.op   = 3'b000;
                bus.srca = 32'd1;
                bus.srcb = 32'd1;
            end
            if (bus.done) done_at = m;
        end
        bus.start = 1'b0;
        chk("b2b second latency", 32'(done_at), 32'd35);
        chk("b2b second result", bus.result, 32'd14);
        extra = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (bus.done) extra++;
        end
        chk("busy start ignored", 32'(extra), 32'd0);

        // Asynchronous reset in the middle of an operation
        bus.start = 1'b1;
        bus.op    = 3'b101;
        bus.srca  = 32'd100;
        bus.srcb  = 32'd7;
        for (int n = 0; n < 6; n++) begin
            step();
            bus.start = 1'b0;
        end
        chk("pre-reset busy", {31'd0, bus.busy}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midop reset busy", {31'd0, bus.busy}, 32'd0);
        chk("midop reset done", {31'd0, bus.done}, 32'd0);
        chk("midop reset result", bus.result, 32'd0);
        step();
        rst_n = 1'b1;
        extra = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (bus.done) extra++;
        end
        chk("reset no done", 32'(extra), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative RV32M multiply/divide sequencer beside the single-cycle ALU in the execute stage. Accepts one operation on a start pulse and runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles. Holds the pipeline via busy and returns one result with a one-cycle done pulse. Execute selects its result instead of the ALU result for M-extension instructions.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
clk     input   1      clock; all state on rising edge
rst_n   input   1      asynchronous active-low reset
start   input   1      request; sampled only when not busy
op      input   3      funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
srca    input   WIDTH  rs1 operand (multiplicand / dividend)
srcb    input   WIDTH  rs2 operand (multiplier / divisor)
flush   input   1      pipeline flush; aborts any operation
busy    output  1      operation in progress; execute stall
done    output  1      one-cycle result-valid pulse
result  output  WIDTH  registered result; held until the next done

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, result=0, counter=0, all operand/accumulator registers 0.
- States: IDLE, PREP, MUL, DIV, FIXUP, DONE.
- IDLE: if start=1 and flush=0, capture op, srca and srcb; go to PREP.
- PREP (1 cycle):
  - Take magnitudes of signed operands: MULH both, MULHSU srca only, DIV/REM both.
  - Record result sign: product sign = XOR of operand signs; quotient sign = XOR; remainder sign = dividend sign.
  - Load counter=WIDTH-1; go to MUL (op[2]=0) or DIV (op[2]=1).
- MUL (WIDTH cycles): 2*WIDTH-bit product register; add shifted multiplicand when the multiplier LSB is 1; shift. Exit to FIXUP when counter=0.
- DIV (WIDTH cycles): restoring. Shift {rem,quot} left 1; trial subtract divisor from the WIDTH+1-bit partial remainder; keep on non-negative and set the quotient bit. Exit to FIXUP when counter=0.
- FIXUP (1 cycle): apply recorded signs (two's complement negate), then select the output:
  - MUL: low half.
  - MULH/MULHSU/MULHU: high half.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Register the selection into result; go to DONE.
- DONE (1 cycle): done=1, busy=0. Accepts a new start in the same cycle (back-to-back): go to PREP, else IDLE.
- busy=1 in PREP, MUL, DIV, FIXUP; 0 in IDLE and DONE.
- Latency: start-sampling cycle = cycle 0; done high in cycle WIDTH+3 (35 for WIDTH=32). Fixed for every op and operand value unless the optional feature is enabled.
- Division corner cases (RISC-V defined):
  - Divisor 0: quotient all ones; remainder = dividend. Sign fixup is suppressed.
  - Signed overflow (DIV/REM, srca=0x80000000, srcb=0xFFFFFFFF): quotient 0x80000000; remainder 0.
  - Both are detected in PREP and forced in FIXUP.
- start while busy=1: ignored. Inputs srca/srcb/op may change freely after capture.
- flush=1: next edge goes to IDLE from any state; busy=0 and no done for the aborted op. result keeps its previous value. flush and start in the same cycle: flush wins, start is dropped.
- Reset mid-operation: immediate return to reset values; no done.
- Arithmetic is modulo 2^(2*WIDTH) internally; no overflow flag.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: PREP jumps directly to FIXUP when any of these hold:
  - divide by zero
  - signed divide overflow
  - MUL-class op with srca=0 or srcb=0 (result 0)
- Early-out gives done in cycle 3 instead of cycle WIDTH+3.
- Undefined: all ops take the fixed WIDTH+3 latency.
- Result values are identical in both builds.

Test Plan:
- Reset: rst_n low mid-cycle -> busy=0, done=0, result=0 immediately. MUL 7 x 0xFFFFFFFD (-3) -> result 0xFFFFFFEB, done exactly in cycle 35, busy high cycles 1-34.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same -> 0. Check 35-cycle latency without MULDIV_EARLY_OUT_EN and 3 cycles with it.
- flush in cycle 10 of a DIV -> busy low in cycle 11, no done, result unchanged. Next MUL 6x7 -> 42.
- start held high across a DONE cycle with a new op -> second op accepted in the DONE cycle, second done 35 cycles later. start pulses while busy -> ignored, no extra done.
